mmio_ctrl: RTL and testbench
============================

Name: mmio_ctrl

Overview:
Parametrised memory-mapped I/O controller between the CPU memory port (mem_cmd/mem_addr/write_data/read_data) and the RAM plus N_OUT output and N_IN input peripheral channels.
- Replaces ad-hoc tri-state/equality decoding with one registered read mux.
- Each output register supports set/clear/toggle.
- Each input channel is synchronised and has sticky rising-edge capture with read-to-clear.
- An unmapped-access error flag is provided.

Parameters:
ADDR_W, 9, CPU address width; MSB=0 selects RAM, MSB=1 selects I/O space
DATA_W, 16, CPU data width
IO_W, 8, width of each I/O channel (IO_W <= DATA_W)
N_OUT, 2, number of output channels (1..8)
N_IN, 2, number of input channels (1..8)
IO_BASE, 9'h100, base address of the I/O register map

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
mem_cmd  in  2  MNONE/MREAD/MWRITE from CPU
mem_addr  in  ADDR_W  CPU word address
write_data  in  DATA_W  CPU write data
read_data  out  DATA_W  read data to CPU, valid 1 cycle after MREAD
ram_rdata  in  DATA_W  synchronous RAM read port
ram_write  out  1  RAM write enable (combinational)
in_ports  in  N_IN*IO_W  raw asynchronous inputs, channel j at [j*IO_W +: IO_W]
out_ports  out  N_OUT*IO_W  registered outputs, channel k at [k*IO_W +: IO_W]
err  out  1  sticky unmapped-access flag

Behaviour:
- Decode: ram_sel = (mem_addr[ADDR_W-1]==0). ram_write = ram_sel & mem_cmd==MWRITE. RAM address is driven outside this block from mem_addr[ADDR_W-2:0].
- I/O map, off = mem_addr-IO_BASE:
  - OUT k: off 4k+0 DATA (R/W), 4k+1 SET (W: out|=wd), 4k+2 CLR (W: out&=~wd), 4k+3 TOG (W: out^=wd). wd = write_data[IO_W-1:0].
  - IN j: off 8'h40+2j LEVEL (R), 8'h40+2j+1 EDGE (R, read-to-clear).
  - off 8'h7F STATUS (R: bit0 = err; W any value: clears err).
- Reads of DATA, SET, CLR and TOG all return the current out value.
- Read data zero-extended to DATA_W.
- Read latency exactly 1 cycle, matching RAM:
  - sel_ram_q <= ram_sel & MREAD.
  - io_rdata_q <= decoded I/O value on MREAD, else holds.
  - read_data = sel_ram_q ? ram_rdata : io_rdata_q.
- Input path:
  - 2-flop synchroniser per bit gives LEVEL (lvl).
  - Third flop lvl_d; edge_set = lvl & ~lvl_d.
  - EDGE <= (EDGE & ~clr_mask) | edge_set. clr_mask is all-ones on an MREAD of that EDGE register.
  - Simultaneous edge and clear: set wins, so the new edge is retained and the read returns the pre-clear value.
- Unmapped: any I/O-space MREAD/MWRITE not in the map sets err.
  - Unmapped read returns 0.
  - Unmapped write has no side effect.
  - err is cleared only by a STATUS write or by reset. A STATUS write is mapped and does not set err.
- MNONE: no state change except synchronisers and edge capture.
- Reset (async, active-low), all to zero immediately on reset=0, regardless of any access in flight:
  - out_ports, EDGE, synchronisers, lvl_d
  - io_rdata_q, sel_ram_q, so read_data = 0
  - err
- First cycle after release: no spurious edge, because lvl_d also resets to 0 and input must rise after 2 sync cycles.

Decomposition:
- Package mmio_pkg:
  - mem_cmd_t enum: MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10.
  - Offset constants: OUT_STRIDE=4, OFF_SET=1, OFF_CLR=2, OFF_TOG=3, IN_BASE=8'h40, OFF_STATUS=8'h7F.
- One sub-module, mmio_in_chan: per-channel synchroniser, edge detect and sticky EDGE register with clear input. Instantiated N_IN times via generate.
- Output registers and decode stay in the top.

Test Plan:
- Reset=0 mid-write to OUT0 -> out_ports=0, read_data=0, err=0 asynchronously; after release, read OUT0 DATA -> 0.
- MWRITE 0x100=0xA5, then MWRITE 0x101=0x0A, 0x102=0x81, 0x103=0xFF -> out0 = 0xA5, 0xAF, 0x2E, 0xD1 on successive cycles; MREAD 0x100 -> read_data=0x00D1 one cycle later.
- in_ports ch1 goes 0x00 -> 0x3C: LEVEL 0x142 reads 0x3C from the 3rd cycle after the change; EDGE 0x143 -> 0x3C, second read -> 0x00.
- EDGE read in the same cycle a new rising edge on bit7 arrives -> read returns old value, EDGE afterward = 0x80.
- MWRITE 0x005=0x1234 asserts ram_write only that cycle; MREAD 0x005 -> read_data = ram_rdata the next cycle; MREAD 0x100 -> no ram_write.
- MREAD 0x160 (unmapped) -> read_data=0, err=1; MREAD 0x17F -> 0x0001; MWRITE 0x17F -> err=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and register-map constants for the memory-mapped I/O controller.
package mmio_pkg;

  // CPU memory-port command encoding.
  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  // Offsets relative to the I/O base address.
  localparam int OUT_STRIDE = 4;      // each output channel occupies 4 words
  localparam int OFF_DATA   = 0;
  localparam int OFF_SET    = 1;
  localparam int OFF_CLR    = 2;
  localparam int OFF_TOG    = 3;
  localparam int IN_BASE    = 'h40;   // input channel j: LEVEL at +2j, EDGE at +2j+1
  localparam int OFF_STATUS = 'h7F;

endpackage

// File: rtl/mmio_in_chan.sv
// One input channel: 2-flop synchroniser, rising-edge detect and a sticky
// EDGE register that clears on read. A new edge in the clearing cycle wins.
module mmio_in_chan #(
  parameter int IO_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IO_W-1:0] i_raw,
  input  logic            i_clr,
  output logic [IO_W-1:0] o_lvl,
  output logic [IO_W-1:0] o_edge
);

  logic [IO_W-1:0] r_sync1;
  logic [IO_W-1:0] r_sync2;
  logic [IO_W-1:0] r_lvl_d;
  logic [IO_W-1:0] r_edge;
  logic [IO_W-1:0] w_edge_set;

  assign w_edge_set = r_sync2 & ~r_lvl_d;
  assign o_lvl      = r_sync2;
  assign o_edge     = r_edge;

  // Synchronise the raw input, delay the level once more, and accumulate edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_lvl_d <= '0;
      r_edge  <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_lvl_d <= r_sync2;
      r_edge  <= (r_edge & ~{IO_W{i_clr}}) | w_edge_set;
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: splits CPU accesses between RAM and an I/O
// register map (set/clear/toggle outputs, synchronised inputs with sticky
// edge capture, status/error flag) and returns reads through one registered mux.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int              ADDR_W  = 9,
  parameter int              DATA_W  = 16,
  parameter int              IO_W    = 8,
  parameter int              N_OUT   = 2,
  parameter int              N_IN    = 2,
  parameter logic [ADDR_W-1:0] IO_BASE = 'h100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mem_cmd,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     write_data,
  output logic [DATA_W-1:0]     read_data,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic                  ram_write,
  input  logic [N_IN*IO_W-1:0]  in_ports,
  output logic [N_OUT*IO_W-1:0] out_ports,
  output logic                  err
);

  mem_cmd_t          w_cmd;
  logic              w_ram_sel;
  logic              w_io_sel;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W-1:0] w_off;
  logic [IO_W-1:0]   w_wd;
  logic              w_mapped;
  logic              w_unmapped;
  logic              w_status_wr;
  logic [DATA_W-1:0] w_io_rval;
  logic [N_IN-1:0]   w_edge_clr;
  logic              w_unused;

  logic [IO_W-1:0]   w_out_nxt [N_OUT];
  logic [IO_W-1:0]   r_out     [N_OUT];
  logic [IO_W-1:0]   w_lvl     [N_IN];
  logic [IO_W-1:0]   w_edge    [N_IN];

  logic              r_err;
  logic              r_sel_ram;
  logic [DATA_W-1:0] r_io_rdata;

  assign w_cmd     = mem_cmd_t'(mem_cmd);
  assign w_io_sel  = mem_addr[ADDR_W-1];
  assign w_ram_sel = ~mem_addr[ADDR_W-1];
  assign w_rd      = (w_cmd == MREAD);
  assign w_wr      = (w_cmd == MWRITE);
  assign w_off     = mem_addr - IO_BASE;
  assign w_wd      = write_data[IO_W-1:0];
  assign ram_write = w_ram_sel & w_wr;
  // Upper write-data bits are only meaningful for RAM, which is written outside this block.
  assign w_unused  = ^write_data;

  // Decode the I/O offset into a read value, output-register updates and side effects.
  // NOTE: every signal gets a default before any condition, so no path can infer a latch.
  always_comb begin
    w_mapped    = 1'b0;
    w_io_rval   = '0;
    w_status_wr = 1'b0;
    w_edge_clr  = '0;
    for (int k = 0; k < N_OUT; k++) begin
      w_out_nxt[k] = r_out[k];
    end

    for (int k = 0; k < N_OUT; k++) begin
      for (int m = 0; m < OUT_STRIDE; m++) begin
        if (w_off == ADDR_W'(OUT_STRIDE * k + m)) begin
          w_mapped  = 1'b1;
          w_io_rval = DATA_W'(r_out[k]);
          if (w_io_sel && w_wr) begin
            case (m)
              OFF_DATA: w_out_nxt[k] = w_wd;
              OFF_SET:  w_out_nxt[k] = r_out[k] | w_wd;
              OFF_CLR:  w_out_nxt[k] = r_out[k] & ~w_wd;
              OFF_TOG:  w_out_nxt[k] = r_out[k] ^ w_wd;
              default:  w_out_nxt[k] = r_out[k];
            endcase
          end
        end
      end
    end

    for (int j = 0; j < N_IN; j++) begin
      if (w_off == ADDR_W'(IN_BASE + 2 * j)) begin
        w_mapped  = 1'b1;
        w_io_rval = DATA_W'(w_lvl[j]);
      end
      if (w_off == ADDR_W'(IN_BASE + 2 * j + 1)) begin
        w_mapped      = 1'b1;
        w_io_rval     = DATA_W'(w_edge[j]);
        w_edge_clr[j] = w_io_sel & w_rd;
      end
    end

    if (w_off == ADDR_W'(OFF_STATUS)) begin
      w_mapped    = 1'b1;
      w_io_rval   = DATA_W'(r_err);
      w_status_wr = w_io_sel & w_wr;
    end
  end

  assign w_unmapped = w_io_sel & (w_rd | w_wr) & ~w_mapped;

  // Output channel registers.
  // NOTE: flop state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_OUT; k++) begin
        r_out[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        r_out[k] <= w_out_nxt[k];
      end
    end
  end

  // Sticky unmapped-access flag; a STATUS write clears it and takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_status_wr) begin
      r_err <= 1'b0;
    end else if (w_unmapped) begin
      r_err <= 1'b1;
    end
  end

  // One-cycle read pipeline matching the synchronous RAM latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel_ram  <= 1'b0;
      r_io_rdata <= '0;
    end else begin
      r_sel_ram <= w_ram_sel & w_rd;
      if (w_io_sel && w_rd) begin
        r_io_rdata <= w_io_rval;
      end
    end
  end

  assign read_data = r_sel_ram ? ram_rdata : r_io_rdata;
  assign err       = r_err;

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign out_ports[k*IO_W +: IO_W] = r_out[k];
  end

  for (genvar j = 0; j < N_IN; j++) begin : g_in
    mmio_in_chan #(
      .IO_W (IO_W)
    ) u_in_chan (
      .clk    (clk),
      .reset  (reset),
      .i_raw  (in_ports[j*IO_W +: IO_W]),
      .i_clr  (w_edge_clr[j]),
      .o_lvl  (w_lvl[j]),
      .o_edge (w_edge[j])
    );
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl. Expected read data is queued when a read is
// issued; a monitor pops and compares one cycle after each MREAD.
module tb_mmio_ctrl;
  import mmio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic [15:0] ram_rdata;
  logic        ram_write;
  logic [15:0] in_ports;
  logic [15:0] out_ports;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q  [$];
  string       name_q [$];

  // Simple synchronous RAM model on the RAM side of the decode.
  logic [15:0] ram [256];

  mmio_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .ram_rdata  (ram_rdata),
    .ram_write  (ram_write),
    .in_ports   (in_ports),
    .out_ports  (out_ports),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) ram[mem_addr[7:0]] <= write_data;
    ram_rdata <= ram[mem_addr[7:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wd;
  endtask

  task automatic issue_rd(input logic [8:0] addr, input logic [15:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    drive(MREAD, addr, 16'h0000);
  endtask

  task automatic rd(input logic [8:0] addr, input logic [15:0] exp, input string name);
    issue_rd(addr, exp, name);
    @(negedge clk);
  endtask

  task automatic wr(input logic [8:0] addr, input logic [15:0] wd);
    drive(MWRITE, addr, wd);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(MNONE, 9'h000, 16'h0000);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: read_data is valid on the cycle after an MREAD is sampled.
  initial begin
    logic was_rd;
    string nm;
    forever begin
      @(posedge clk);
      was_rd = (mem_cmd == MREAD) && reset;
      @(negedge clk);
      if (was_rd) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_read: got %h expected no read", read_data);
        end else begin
          nm = name_q.pop_front();
          check(nm, 32'(read_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b0;
    in_ports = 16'h0000;
    idle(0);
    repeat (3) @(negedge clk);
    check("rst_out", 32'(out_ports), 32'h0);
    check("rst_rdata", 32'(read_data), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Put state into every reset-cleared register, then reset mid-write.
    wr(9'h100, 16'h0055);
    check("out0_pre_rst", 32'(out_ports), 32'h0055);
    rd(9'h160, 16'h0000, "unmapped_pre_rst");
    rd(9'h100, 16'h0055, "out0_pre_rst_rd");
    check("err_pre_rst", 32'(err), 32'h1);
    drive(MWRITE, 9'h100, 16'h00AA);
    #2 reset = 1'b0;
    #1;
    check("async_rst_out", 32'(out_ports), 32'h0);
    check("async_rst_rdata", 32'(read_data), 32'h0);
    check("async_rst_err", 32'(err), 32'h0);
    @(negedge clk);
    idle(0);
    reset = 1'b1;
    @(negedge clk);
    rd(9'h100, 16'h0000, "out0_after_rst");

    // DATA / SET / CLR / TOG on output 0.
    wr(9'h100, 16'h00A5);
    check("out0_data", 32'(out_ports), 32'h00A5);
    wr(9'h101, 16'h000A);
    check("out0_set", 32'(out_ports), 32'h00AF);
    wr(9'h102, 16'h0081);
    check("out0_clr", 32'(out_ports), 32'h002E);
    wr(9'h103, 16'hFFFF);
    check("out0_tog", 32'(out_ports), 32'h00D1);
    rd(9'h100, 16'h00D1, "out0_rd_data");
    rd(9'h103, 16'h00D1, "out0_rd_tog");

    // Output 1, independent of output 0.
    wr(9'h107, 16'h000F);
    check("out1_tog", 32'(out_ports), 32'h0FD1);
    wr(9'h105, 16'h00F0);
    check("out1_set", 32'(out_ports), 32'hFFD1);
    rd(9'h106, 16'h00FF, "out1_rd_clr");

    // RAM path: write strobe only for RAM writes, RAM data muxed back.
    drive(MWRITE, 9'h005, 16'h1234);
    #1 check("ram_write_wr", 32'(ram_write), 32'h1);
    @(negedge clk);
    issue_rd(9'h005, 16'h1234, "ram_rd");
    #1 check("ram_write_rd", 32'(ram_write), 32'h0);
    @(negedge clk);
    issue_rd(9'h100, 16'h00D1, "io_after_ram_rd");
    #1 check("ram_write_io", 32'(ram_write), 32'h0);
    @(negedge clk);
    drive(MWRITE, 9'h101, 16'h0000);
    #1 check("ram_write_io_wr", 32'(ram_write), 32'h0);
    @(negedge clk);

    // Input channel 1: synchroniser latency, edge capture, read-to-clear.
    in_ports[15:8] = 8'h3C;
    idle(1);
    rd(9'h142, 16'h0000, "level_early");
    rd(9'h142, 16'h003C, "level_sync");
    rd(9'h143, 16'h003C, "edge_first");
    rd(9'h143, 16'h0000, "edge_cleared");
    rd(9'h140, 16'h0000, "level_ch0");
    rd(9'h141, 16'h0000, "edge_ch0");

    // New edge on bit 7 lands in the same cycle as an EDGE read: set wins.
    in_ports[15:8] = 8'hBC;
    idle(2);
    rd(9'h143, 16'h0000, "edge_race_old");
    rd(9'h143, 16'h0080, "edge_race_kept");
    rd(9'h143, 16'h0000, "edge_race_clr");

    // Unmapped accesses, STATUS read and clear.
    check("err_idle", 32'(err), 32'h0);
    rd(9'h160, 16'h0000, "unmapped_rd");
    check("err_set_rd", 32'(err), 32'h1);
    wr(9'h17F, 16'h0000);
    check("err_clr", 32'(err), 32'h0);
    wr(9'h108, 16'h00FF);
    check("unmapped_wr_noeff", 32'(out_ports), 32'hFFD1);
    check("err_set_wr", 32'(err), 32'h1);
    rd(9'h17F, 16'h0001, "status_rd");
    check("err_after_status_rd", 32'(err), 32'h1);
    wr(9'h17F, 16'h1234);
    check("err_clr_any", 32'(err), 32'h0);
    rd(9'h17F, 16'h0000, "status_rd_clr");
    check("err_status_mapped", 32'(err), 32'h0);

    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
